cpu_sequencer: RTL and testbench

Multicycle control FSM for the 16-bit CPU. It owns fetch, PC update, decode dispatch and execute sequencing for the register file / shifter / ALU datapath and the single-port synchronous RAM. Each cycle it drives every datapath enable and mux select from its current state (Moore outputs). It sits beside the instruction decoder and replaces any ad-hoc sequencing in the CPU top.

---
 rtl/cpu_sequencer.sv | 254 +++++++++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Multicycle control FSM for the 16-bit CPU: fetch, PC update, decode dispatch and
// execute sequencing. Every datapath control is a Moore decode of the state.
module cpu_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic       waiting,
    output logic [1:0] reg_sel,
    output logic [1:0] wb_sel,
    output logic       w_en,
    output logic       load_ir,
    output logic       load_pc,
    output logic       clear_pc,
    output logic       load_addr,
    output logic       en_A,
    output logic       en_B,
    output logic       en_C,
    output logic       en_status,
    output logic       sel_A,
    output logic       sel_B,
    output logic       no_shift,
    output logic       sel_addr,
    output logic       ram_w_en
);

    typedef enum logic [4:0] {
        S_RST     = 5'd0,
        S_IF1     = 5'd1,
        S_IF2     = 5'd2,
        S_UPC     = 5'd3,
        S_DEC     = 5'd4,
        S_MOVI    = 5'd5,
        S_GET_A   = 5'd6,
        S_GET_B   = 5'd7,
        S_EXEC    = 5'd8,
        S_WB      = 5'd9,
        S_ADDR    = 5'd10,
        S_LDA     = 5'd11,
        S_LD_MEM  = 5'd12,
        S_LD_WB   = 5'd13,
        S_GET_RD  = 5'd14,
        S_ST_PASS = 5'd15,
        S_ST_WR   = 5'd16,
        S_HALT    = 5'd17
    } state_t;

    // Instruction class captured in DEC, so later states never look at opcode/op.
    typedef enum logic [2:0] {
        K_NONE = 3'd0,
        K_MOVR = 3'd1,
        K_ALU  = 3'd2,
        K_CMP  = 3'd3,
        K_LDR  = 3'd4,
        K_STR  = 3'd5
    } kind_t;

    typedef struct packed {
        logic       waiting;
        logic [1:0] reg_sel;
        logic [1:0] wb_sel;
        logic       w_en;
        logic       load_ir;
        logic       load_pc;
        logic       clear_pc;
        logic       load_addr;
        logic       en_a;
        logic       en_b;
        logic       en_c;
        logic       en_status;
        logic       sel_a;
        logic       sel_b;
        logic       no_shift;
        logic       sel_addr;
        logic       ram_w_en;
    } ctrl_t;

    localparam logic [1:0] REG_RM = 2'b00;
    localparam logic [1:0] REG_RD = 2'b01;
    localparam logic [1:0] REG_RN = 2'b10;
    localparam logic [1:0] WB_C   = 2'b00;
    localparam logic [1:0] WB_IMM = 2'b10;
    localparam logic [1:0] WB_MEM = 2'b11;

    state_t state, nxt_state;
    kind_t  kind, nxt_kind;
    ctrl_t  ctrl;

    function automatic ctrl_t decode(input state_t s, input kind_t k);
        ctrl_t c;
        c = '0;
        case (s)
            S_RST: begin
                c.load_pc  = 1'b1;
                c.clear_pc = 1'b1;
                c.sel_addr = 1'b1;
            end
            S_IF1:  c.sel_addr = 1'b1;
            S_IF2: begin
                c.sel_addr = 1'b1;
                c.load_ir  = 1'b1;
            end
            S_UPC:  c.load_pc = 1'b1;
            S_MOVI: begin
                c.reg_sel = REG_RN;
                c.wb_sel  = WB_IMM;
                c.w_en    = 1'b1;
            end
            S_GET_A: begin
                c.reg_sel = REG_RN;
                c.en_a    = 1'b1;
            end
            S_GET_B: begin
                c.reg_sel = REG_RM;
                c.en_b    = 1'b1;
            end
            S_EXEC: begin
                // MOV reg computes 0 + shifted Rm through the ALU.
                c.sel_a     = (k == K_MOVR);
                c.en_status = (k == K_CMP);
                c.en_c      = (k != K_CMP);
            end
            S_WB: begin
                c.reg_sel = REG_RD;
                c.wb_sel  = WB_C;
                c.w_en    = 1'b1;
            end
            S_ADDR: begin
                c.sel_b    = 1'b1;
                c.no_shift = 1'b1;
                c.en_c     = 1'b1;
            end
            S_LDA:  c.load_addr = 1'b1;
            S_LD_WB: begin
                c.reg_sel = REG_RD;
                c.wb_sel  = WB_MEM;
                c.w_en    = 1'b1;
            end
            S_GET_RD: begin
                c.reg_sel = REG_RD;
                c.en_b    = 1'b1;
            end
            S_ST_PASS: begin
                c.sel_a    = 1'b1;
                c.no_shift = 1'b1;
                c.en_c     = 1'b1;
            end
            S_ST_WR: c.ram_w_en = 1'b1;
            S_HALT:  c.waiting  = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        nxt_state = state;
        nxt_kind  = kind;
        case (state)
            S_RST: nxt_state = S_IF1;
            S_IF1: nxt_state = S_IF2;
            S_IF2: nxt_state = S_UPC;
            S_UPC: nxt_state = S_DEC;
            S_DEC: begin
                nxt_kind = K_NONE;
                case ({opcode, op})
                    5'b11010: nxt_state = S_MOVI;
                    5'b11000: begin
                        nxt_state = S_GET_B;
                        nxt_kind  = K_MOVR;
                    end
                    5'b10100, 5'b10110: begin
                        nxt_state = S_GET_A;
                        nxt_kind  = K_ALU;
                    end
                    5'b10101: begin
                        nxt_state = S_GET_A;
                        nxt_kind  = K_CMP;
                    end
                    5'b10111: begin
                        nxt_state = S_GET_B;
                        nxt_kind  = K_ALU;
                    end
                    5'b01100: begin
                        nxt_state = S_GET_A;
                        nxt_kind  = K_LDR;
                    end
                    5'b10000: begin
                        nxt_state = S_GET_A;
                        nxt_kind  = K_STR;
                    end
                    default: nxt_state = S_HALT;
                endcase
            end
            S_MOVI:    nxt_state = S_IF1;
            S_GET_A:   nxt_state = (kind == K_LDR || kind == K_STR) ? S_ADDR : S_GET_B;
            S_GET_B:   nxt_state = S_EXEC;
            S_EXEC:    nxt_state = (kind == K_CMP) ? S_IF1 : S_WB;
            S_WB:      nxt_state = S_IF1;
            S_ADDR:    nxt_state = S_LDA;
            S_LDA:     nxt_state = (kind == K_LDR) ? S_LD_MEM : S_GET_RD;
            S_LD_MEM:  nxt_state = S_LD_WB;
            S_LD_WB:   nxt_state = S_IF1;
            S_GET_RD:  nxt_state = S_ST_PASS;
            S_ST_PASS: nxt_state = S_ST_WR;
            S_ST_WR:   nxt_state = S_IF1;
            S_HALT:    nxt_state = S_HALT;
            default:   nxt_state = S_HALT;
        endcase
    end

    // Controls are registered from the next state, so they always equal the decode
    // of the state register; async reset drops them together with the state.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RST;
            kind  <= K_NONE;
            ctrl  <= decode(S_RST, K_NONE);
        end else begin
            state <= nxt_state;
            kind  <= nxt_kind;
            ctrl  <= decode(nxt_state, nxt_kind);
        end
    end

    assign waiting   = ctrl.waiting;
    assign reg_sel   = ctrl.reg_sel;
    assign wb_sel    = ctrl.wb_sel;
    assign w_en      = ctrl.w_en;
    assign load_ir   = ctrl.load_ir;
    assign load_pc   = ctrl.load_pc;
    assign clear_pc  = ctrl.clear_pc;
    assign load_addr = ctrl.load_addr;
    assign en_A      = ctrl.en_a;
    assign en_B      = ctrl.en_b;
    assign en_C      = ctrl.en_c;
    assign en_status = ctrl.en_status;
    assign sel_A     = ctrl.sel_a;
    assign sel_B     = ctrl.sel_b;
    assign no_shift  = ctrl.no_shift;
    assign sel_addr  = ctrl.sel_addr;
    assign ram_w_en  = ctrl.ram_w_en;

    // A RAM write must always use the data-address register, never the PC.
    a_wr_uses_data_addr: assert property (@(posedge clk) disable iff (!rst_n)
        ram_w_en |-> !sel_addr);

    a_waiting_only_in_halt: assert property (@(posedge clk) disable iff (!rst_n)
        waiting |-> (state == S_HALT));

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: expected per-cycle control vectors are queued
// per instruction and compared each cycle on the falling clock edge.
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] opcode;
    logic [1:0] op;
    logic       waiting, w_en, load_ir, load_pc, clear_pc, load_addr;
    logic       en_A, en_B, en_C, en_status, sel_A, sel_B, no_shift, sel_addr, ram_w_en;
    logic [1:0] reg_sel, wb_sel;

    int n_checks = 0;
    int n_errors = 0;

    typedef enum {
        T_RST, T_IF1, T_IF2, T_UPC, T_DEC, T_MOVI, T_GET_A, T_GET_B,
        T_EXEC_MOV, T_EXEC_ALU, T_EXEC_CMP, T_WB, T_ADDR, T_LDA, T_LD_MEM,
        T_LD_WB, T_GET_RD, T_ST_PASS, T_ST_WR, T_HALT
    } tb_st_t;

    tb_st_t exp_q[$];

    cpu_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .op        (op),
        .waiting   (waiting),
        .reg_sel   (reg_sel),
        .wb_sel    (wb_sel),
        .w_en      (w_en),
        .load_ir   (load_ir),
        .load_pc   (load_pc),
        .clear_pc  (clear_pc),
        .load_addr (load_addr),
        .en_A      (en_A),
        .en_B      (en_B),
        .en_C      (en_C),
        .en_status (en_status),
        .sel_A     (sel_A),
        .sel_B     (sel_B),
        .no_shift  (no_shift),
        .sel_addr  (sel_addr),
        .ram_w_en  (ram_w_en)
    );

    always #5 clk = ~clk;

    logic [18:0] obs;
    assign obs = {waiting, reg_sel, wb_sel, w_en, load_ir, load_pc, clear_pc, load_addr,
                  en_A, en_B, en_C, en_status, sel_A, sel_B, no_shift, sel_addr, ram_w_en};

    // Control table straight from the state descriptions; unlisted outputs are 0.
    function automatic logic [18:0] exp_vec(input tb_st_t s);
        logic       wt, we, lir, lpc, cpc, lad, ea, eb, ec, es, sa, sb, ns, sad, rw;
        logic [1:0] rs, ws;
        {wt, we, lir, lpc, cpc, lad, ea, eb, ec, es, sa, sb, ns, sad, rw} = '0;
        rs = 2'b00;
        ws = 2'b00;
        case (s)
            T_RST:      begin lpc = 1; cpc = 1; sad = 1; end
            T_IF1:      sad = 1;
            T_IF2:      begin sad = 1; lir = 1; end
            T_UPC:      lpc = 1;
            T_MOVI:     begin rs = 2'b10; ws = 2'b10; we = 1; end
            T_GET_A:    begin rs = 2'b10; ea = 1; end
            T_GET_B:    eb = 1;
            T_EXEC_MOV: begin sa = 1; ec = 1; end
            T_EXEC_ALU: ec = 1;
            T_EXEC_CMP: es = 1;
            T_WB:       begin rs = 2'b01; we = 1; end
            T_ADDR:     begin sb = 1; ns = 1; ec = 1; end
            T_LDA:      lad = 1;
            T_LD_WB:    begin rs = 2'b01; ws = 2'b11; we = 1; end
            T_GET_RD:   begin rs = 2'b01; eb = 1; end
            T_ST_PASS:  begin sa = 1; ns = 1; ec = 1; end
            T_ST_WR:    rw = 1;
            T_HALT:     wt = 1;
            default:    ;
        endcase
        return {wt, rs, ws, we, lir, lpc, cpc, lad, ea, eb, ec, es, sa, sb, ns, sad, rw};
    endfunction

    task automatic check(input string tag, input logic [18:0] got, input logic [18:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %05h expected %05h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_instr(input logic [2:0] opc, input logic [1:0] o, input int halt_cycles);
        exp_q.push_back(T_IF1);
        exp_q.push_back(T_IF2);
        exp_q.push_back(T_UPC);
        exp_q.push_back(T_DEC);
        case ({opc, o})
            5'b11010: exp_q.push_back(T_MOVI);
            5'b11000: begin exp_q.push_back(T_GET_B); exp_q.push_back(T_EXEC_MOV); exp_q.push_back(T_WB); end
            5'b10100, 5'b10110: begin
                exp_q.push_back(T_GET_A); exp_q.push_back(T_GET_B);
                exp_q.push_back(T_EXEC_ALU); exp_q.push_back(T_WB);
            end
            5'b10101: begin exp_q.push_back(T_GET_A); exp_q.push_back(T_GET_B); exp_q.push_back(T_EXEC_CMP); end
            5'b10111: begin exp_q.push_back(T_GET_B); exp_q.push_back(T_EXEC_ALU); exp_q.push_back(T_WB); end
            5'b01100: begin
                exp_q.push_back(T_GET_A); exp_q.push_back(T_ADDR); exp_q.push_back(T_LDA);
                exp_q.push_back(T_LD_MEM); exp_q.push_back(T_LD_WB);
            end
            5'b10000: begin
                exp_q.push_back(T_GET_A); exp_q.push_back(T_ADDR); exp_q.push_back(T_LDA);
                exp_q.push_back(T_GET_RD); exp_q.push_back(T_ST_PASS); exp_q.push_back(T_ST_WR);
            end
            default: for (int i = 0; i < halt_cycles; i++) exp_q.push_back(T_HALT);
        endcase
    endtask

    // Pops one expectation per cycle; opcode/op are only meaningful in DEC, so
    // they carry random junk in every other cycle.
    task automatic drain(input logic [2:0] opc, input logic [1:0] o);
        tb_st_t s;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            s = exp_q.pop_front();
            check(s.name(), obs, exp_vec(s));
            if (s == T_DEC) begin
                opcode = opc;
                op     = o;
            end else begin
                opcode = 3'($urandom_range(7, 0));
                op     = 2'($urandom_range(3, 0));
            end
        end
    endtask

    task automatic run(input logic [2:0] opc, input logic [1:0] o);
        push_instr(opc, o, 22);
        drain(opc, o);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        opcode = 3'b111;
        op     = 2'b00;

        // Reset held three cycles with junk on the decode inputs.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_held", obs, exp_vec(T_RST));
            opcode = 3'($urandom_range(7, 0));
            op     = 2'($urandom_range(3, 0));
        end
        rst_n = 1'b1;

        run(3'b110, 2'b10);  // MOV imm
        run(3'b110, 2'b00);  // MOV reg
        run(3'b101, 2'b00);  // ADD
        run(3'b101, 2'b01);  // CMP
        run(3'b101, 2'b10);  // AND
        run(3'b101, 2'b11);  // MVN
        run(3'b011, 2'b00);  // LDR
        run(3'b100, 2'b00);  // STR
        run(3'b111, 2'b00);  // HALT

        // Asynchronous reset out of HALT, away from any clock edge.
        #3 rst_n = 1'b0;
        #1 check("async_rst_from_halt", obs, exp_vec(T_RST));
        check("waiting_cleared", {18'd0, waiting}, 19'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run(3'b001, 2'b00);  // illegal code parks in HALT

        #3 rst_n = 1'b0;
        #1 check("async_rst_from_illegal", obs, exp_vec(T_RST));
        @(negedge clk);
        rst_n = 1'b1;

        // STR aborted by reset while the RAM write is in progress.
        push_instr(3'b100, 2'b00, 0);
        void'(exp_q.pop_back());
        drain(3'b100, 2'b00);
        @(negedge clk);
        check("st_wr_before_abort", obs, exp_vec(T_ST_WR));
        #2 rst_n = 1'b0;
        #1 check("st_wr_abort", obs, exp_vec(T_RST));
        check("ram_w_en_dropped", {18'd0, ram_w_en}, 19'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run(3'b110, 2'b10);  // fetch resumes cleanly after the abort

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
